// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: accepts two N-bit operands and a carry-in,
// adds them one bit per clock (LSB first) through a single 1-bit full
// adder cell, then holds the result until the consumer takes it.

// 1-bit full adder cell shared by the serial datapath.
module adder_1 (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

module serial_adder_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         overflow,
    output logic         busy
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [N-1:0]     a_sh_r;
    logic [N-1:0]     b_sh_r;
    logic [N-1:0]     sum_r;
    logic             carry_r;
    logic             c_out_r;
    logic             overflow_r;
    logic [IDX_W-1:0] idx_r;
    logic             fa_sum_s;
    logic             fa_co_s;
    logic             accept_s;
    logic             last_s;

    // Operands are shifted right each RUN cycle, so bit 0 is always the
    // bit at position idx_r of the originally captured operand.
    adder_1 u_fa (
        .a  (a_sh_r[0]),
        .b  (b_sh_r[0]),
        .ci (carry_r),
        .s  (fa_sum_s),
        .co (fa_co_s)
    );

    assign accept_s = in_valid & in_ready;
    assign last_s   = (idx_r == IDX_LAST);

    // State register; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_r)
            ST_IDLE: in_ready = 1'b1;
            ST_RUN:  busy = 1'b1;
            ST_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Serial datapath: operand capture, one sum bit per RUN cycle, and the
    // final carry/overflow capture on the MSB cycle. Results are held in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_r     <= {N{1'b0}};
            b_sh_r     <= {N{1'b0}};
            sum_r      <= {N{1'b0}};
            carry_r    <= 1'b0;
            c_out_r    <= 1'b0;
            overflow_r <= 1'b0;
            idx_r      <= IDX_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_sh_r     <= a;
                        b_sh_r     <= b;
                        carry_r    <= c_in;
                        sum_r      <= {N{1'b0}};
                        c_out_r    <= 1'b0;
                        overflow_r <= 1'b0;
                        idx_r      <= IDX_ZERO;
                    end
                end
                ST_RUN: begin
                    sum_r[idx_r] <= fa_sum_s;
                    carry_r      <= fa_co_s;
                    a_sh_r       <= {1'b0, a_sh_r[N-1:1]};
                    b_sh_r       <= {1'b0, b_sh_r[N-1:1]};
                    if (last_s) begin
                        // carry_r here is the carry into the MSB.
                        c_out_r    <= fa_co_s;
                        overflow_r <= carry_r ^ fa_co_s;
                        idx_r      <= IDX_ZERO;
                    end else begin
                        idx_r <= idx_r + IDX_ONE;
                    end
                end
                ST_DONE: begin
                    idx_r <= IDX_ZERO;
                end
                default: begin
                    idx_r <= IDX_ZERO;
                end
            endcase
        end
    end

    assign sum      = sum_r;
    assign c_out    = c_out_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (N=8): directed vector table,
// backpressure and mid-run reset sequences, and randomized transactions
// checked against an arithmetic reference model.
module tb_serial_adder_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         c_out;
    logic         overflow;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vcin;
        logic [7:0] es;
        logic       eco;
        logic       eov;
    } vec_t;

    typedef struct {
        logic [8:0] full;
        logic       ov;
    } exp_t;

    vec_t vecs[8];
    exp_t expq[$];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One transaction from IDLE: accept, scramble inputs, wait for result,
    // hold backpressure for 'hold' cycles, then consume.
    task automatic do_txn(input logic [7:0] ta, input logic [7:0] tb_v, input logic tcin,
                          input int hold, output logic [7:0] rs, output logic rco,
                          output logic rov, output int lat);
        check("ready_before_accept", 32'(in_ready), 32'd1);
        a = ta; b = tb_v; c_in = tcin; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        a = ~ta; b = ~tb_v; c_in = ~tcin;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick;
            lat++;
        end
        out_ready = 1'b0;
        repeat (hold) tick;
        rs = sum; rco = c_out; rov = overflow;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] rs;
        logic       rco;
        logic       rov;
        int         lat;
        logic       seen;
        logic       done;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        exp_t       e;
        exp_t       f;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};

        // Reset with a concurrent request that must not be taken.
        rst = 1'b1; in_valid = 1'b1; a = 8'hAA; b = 8'h55; c_in = 1'b1; out_ready = 1'b0;
        tick;
        tick;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_c_out", 32'(c_out), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        tick;
        check("no_accept_in_rst_ready", 32'(in_ready), 32'd1);
        check("no_accept_in_rst_busy", 32'(busy), 32'd0);

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i].va, vecs[i].vb, vecs[i].vcin, i % 3, rs, rco, rov, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(N));
            check($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].es));
            check($sformatf("vec%0d_c_out", i), 32'(rco), 32'(vecs[i].eco));
            check($sformatf("vec%0d_overflow", i), 32'(rov), 32'(vecs[i].eov));
            check($sformatf("vec%0d_idle_after", i), 32'(in_ready), 32'd1);
        end

        // Backpressure in DONE with ignored input pulses.
        a = 8'h7F; b = 8'h01; c_in = 1'b0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick;
            lat++;
        end
        check("bp_latency", 32'(lat), 32'(N));
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
            check("bp_sum", 32'(sum), 32'h80);
            check("bp_c_out", 32'(c_out), 32'd0);
            check("bp_overflow", 32'(overflow), 32'd1);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            tick;
        end
        check("bp_still_done", 32'(out_valid), 32'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_busy", 32'(busy), 32'd0);

        // Reset mid-RUN at bit index 4; result must never appear.
        a = 8'h33; b = 8'h44; c_in = 1'b0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        check("accept_clears_sum", 32'(sum), 32'd0);
        check("accept_clears_c_out", 32'(c_out), 32'd0);
        check("accept_clears_overflow", 32'(overflow), 32'd0);
        repeat (4) tick;
        check("midrun_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_c_out", 32'(c_out), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        seen = 1'b0;
        repeat (N + 4) begin
            if (out_valid) seen = 1'b1;
            tick;
        end
        check("midrst_no_out_valid", 32'(seen), 32'd0);
        do_txn(8'h10, 8'h20, 1'b0, 0, rs, rco, rov, lat);
        check("post_rst_latency", 32'(lat), 32'(N));
        check("post_rst_sum", 32'(rs), 32'h30);
        check("post_rst_c_out", 32'(rco), 32'd0);
        check("post_rst_overflow", 32'(rov), 32'd0);

        // Randomized transactions against the arithmetic reference model.
        for (int t = 0; t < 1000; t++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            e.full = 9'(ra) + 9'(rb) + 9'(rc);
            e.ov   = (ra[7] == rb[7]) && (e.full[7] != ra[7]);
            expq.push_back(e);
            a = ra; b = rb; c_in = rc; in_valid = 1'b1;
            tick;
            lat = 0; done = 1'b0; seen = 1'b0;
            while (!done && lat < 60) begin
                in_valid = 1'($urandom);
                a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
                out_ready = 1'($urandom);
                if (out_valid) begin
                    if (!seen) begin
                        seen = 1'b1;
                        check("rand_latency", 32'(lat), 32'(N));
                    end
                    if (out_ready) begin
                        f = expq.pop_front();
                        check("rand_sum", 32'(sum), 32'(f.full[7:0]));
                        check("rand_c_out", 32'(c_out), 32'(f.full[8]));
                        check("rand_overflow", 32'(overflow), 32'(f.ov));
                        done = 1'b1;
                    end
                end
                tick;
                lat++;
            end
            in_valid = 1'b0;
            out_ready = 1'b0;
            if (!done) begin
                n_cmp++;
                n_err++;
                $display("FAIL rand_timeout: txn %0d got no result within 60 cycles, expected one", t);
                expq.delete();
                rst = 1'b1;
                tick;
                rst = 1'b0;
            end
        end
        check("rand_queue_empty", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
